// File: rtl/bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// bin_to_bcd_seq : sequential double-dabble binary-to-BCD converter, one bit per
// clock. Define BIN_TO_BCD_SEG_EN to add the active-low 7-segment decode port.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin_to_bcd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   bin,
  output logic                    busy,
  output logic                    done,
`ifdef BIN_TO_BCD_SEG_EN
  output logic [4*DIGITS-1:0]     bcd,
  output logic [7*DIGITS-1:0]     seg
`else
  output logic [4*DIGITS-1:0]     bcd
`endif
);

  localparam int C_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int C_BCD_W = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_op;
  logic [C_BCD_W-1:0]    r_scratch;
  logic [C_BCD_W-1:0]    w_adj;
  logic [C_BCD_W-1:0]    w_scratch_step;
  logic [C_BCD_W-1:0]    r_bcd;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_CNT_W-1:0]    w_cnt_step;
  logic                  w_last;
  logic                  r_done;

  // Pre-shift correction: any nibble >= 5 would become >= 10 after doubling.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                             (r_scratch[4*i +: 4] + 4'd3) : r_scratch[4*i +: 4];
  end

  assign w_scratch_step = (w_adj << 1) | C_BCD_W'(r_op[DATA_WIDTH-1]);
  assign w_cnt_step     = r_cnt + C_CNT_W'(1);
  assign w_last         = (w_cnt_step == C_CNT_W'(DATA_WIDTH));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op      <= bin;
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          r_op      <= r_op << 1;
          r_scratch <= w_scratch_step;
          r_cnt     <= w_cnt_step;
          // Publish the post-step scratch so the result lands on the final edge.
          if (w_last) begin
            r_bcd  <= w_scratch_step;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;

`ifdef BIN_TO_BCD_SEG_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign seg[7*i +: 7] = seg_decode(r_bcd[4*i +: 4]);
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// tb_bin_to_bcd_seq : directed and random checks of bin_to_bcd_seq against a
// decimal-arithmetic reference. Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bin_to_bcd_seq;

  localparam int DW = 16;
  localparam int DG = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] bin;
  logic          busy;
  logic          done;
  logic [4*DG-1:0] bcd;
`ifdef BIN_TO_BCD_SEG_EN
  logic [7*DG-1:0] seg;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [4*DG-1:0] last_bcd;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef BIN_TO_BCD_SEG_EN
    .bcd   (bcd),
    .seg   (seg)
`else
    .bcd   (bcd)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DG-1:0] ref_bcd(input int unsigned v);
    logic [4*DG-1:0] r;
    int unsigned     x;
    r = '0;
    x = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int unsigned d);
    logic [6:0] tbl [0:9];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 10) ? tbl[d] : 7'b1111111;
  endfunction

  // Convert v; optionally pulse a stray start pulse_at cycles after acceptance.
  // Returns in the done cycle so a caller may issue the next start there.
  task automatic run_conv(input logic [DW-1:0] v, input int pulse_at,
                          input logic [DW-1:0] pulse_val, input string tag);
    int              cyc;
    bit              seen;
    logic [4*DG-1:0] exp;
    exp   = ref_bcd(int'(v));
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = DW'($urandom);
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3*DW) begin
      if (cyc == pulse_at) begin
        start = 1'b1;
        bin   = pulse_val;
      end
      tick();
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
      else check({tag, " hold"}, {busy, bcd}, {1'b1, last_bcd});
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(DW));
    check({tag, " bcd"}, 64'(bcd), 64'(exp));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
`ifdef BIN_TO_BCD_SEG_EN
    for (int i = 0; i < DG; i++)
      check({tag, " seg"}, 64'(seg[7*i +: 7]), 64'(ref_seg(int'(exp[4*i +: 4]))));
`endif
    last_bcd = exp;
  endtask

  task automatic idle_check(input string tag);
    tick();
    check({tag, " done_width"}, {done, busy, bcd}, {1'b0, 1'b0, last_bcd});
  endtask

  initial begin
    logic [DW-1:0] dir_vals [0:9];
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    last_bcd = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset_state", {busy, done, bcd}, '0);
    rst = 1'b0;
    tick();
    check("reset_idle", {busy, done, bcd}, '0);

    dir_vals = '{16'd0, 16'd65535, 16'd1234, 16'd9, 16'd80,
                 16'd1, 16'd10, 16'd9999, 16'd10000, 16'd59999};
    for (int i = 0; i < 10; i++) begin
      run_conv(dir_vals[i], -1, '0, "directed");
      idle_check("directed");
    end

    // Stray start while busy must be ignored.
    run_conv(16'd500, 5, 16'd7, "ignore_busy_start");
    idle_check("ignore_busy_start");
    tick();
    check("ignore_no_extra", {done, busy}, 2'b00);

    // Back-to-back: second start issued in the done cycle of the first.
    run_conv(16'd100, -1, '0, "b2b_first");
    run_conv(16'd4321, -1, '0, "b2b_second");
    idle_check("b2b_second");

    // Reset mid-conversion aborts without done.
    start = 1'b1;
    bin   = 16'd999;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_done_pre", 64'(done), 64'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_reset", {busy, done, bcd}, '0);
    last_bcd = '0;
    for (int i = 0; i < DW + 2; i++) begin
      tick();
      check("abort_no_done_post", {busy, done}, 2'b00);
    end
    run_conv(16'd42, -1, '0, "after_abort");
    idle_check("after_abort");

    for (int n = 0; n < 30; n++) begin
      logic [DW-1:0] v;
      int            p;
      int            gap;
      v   = DW'($urandom_range(0, 65535));
      p   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW-2)) : -1;
      gap = int'($urandom_range(0, 3));
      run_conv(v, p, DW'($urandom), "random");
      if (gap != 0) begin
        idle_check("random");
        for (int g = 1; g < gap; g++) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
